// File: rtl/cbd38_timer_if.sv
// Pin-level bundle for cbd38_timer: load data, control strobes, count and status.
// UFCLR/UF exist only when CBD38_TIMER_UFLAG_EN is defined.
interface cbd38_timer_if;
  logic D0, D1, D2, D3, D4, D5, D6, D7;
  logic BI, EN, LD, PS, START, MODE;
  logic Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
  logic BO, TC, BUSY;
`ifdef CBD38_TIMER_UFLAG_EN
  logic UFCLR, UF;
`endif

  modport master (
    output D0, D1, D2, D3, D4, D5, D6, D7, BI, EN, LD, PS, START, MODE,
`ifdef CBD38_TIMER_UFLAG_EN
    output UFCLR, input UF,
`endif
    input  Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, BO, TC, BUSY
  );

  modport slave (
    input  D0, D1, D2, D3, D4, D5, D6, D7, BI, EN, LD, PS, START, MODE,
`ifdef CBD38_TIMER_UFLAG_EN
    input UFCLR, output UF,
`endif
    output Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, BO, TC, BUSY
  );
endinterface

// File: rtl/cbd38_timer.sv
// Cascadable 8-bit down-counting timer with one-shot/periodic reload.
// Define CBD38_TIMER_UFLAG_EN to add the sticky underflow flag (UFCLR/UF).
module cbd38_timer (
  input logic CLK,
  input logic CD,
  cbd38_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     st, st_n;
  logic [7:0] d, cnt, cnt_n, rld, rld_n;
  logic       tc, tc_n, cnt_en, term;

  assign d      = {bus.D7, bus.D6, bus.D5, bus.D4, bus.D3, bus.D2, bus.D1, bus.D0};
  assign cnt_en = bus.BI & bus.EN;

  assign {bus.Q7, bus.Q6, bus.Q5, bus.Q4, bus.Q3, bus.Q2, bus.Q1, bus.Q0} = cnt;
  // Borrow-out is the raw cascade condition; load/preset do not mask it.
  assign bus.BO   = cnt_en & (st == RUN) & (cnt == 8'h00);
  assign bus.TC   = tc;
  assign bus.BUSY = (st == RUN);

  always_comb begin
    cnt_n = cnt;
    rld_n = rld;
    st_n  = st;
    tc_n  = 1'b0;
    term  = 1'b0;
    if (bus.PS) begin
      cnt_n = 8'hFF;
    end else if (bus.LD) begin
      cnt_n = d;
      rld_n = d;
      if (st != RUN && bus.START) st_n = RUN;
    end else if (bus.START && st != RUN) begin
      if (st == DONE) cnt_n = rld;
      st_n = RUN;
    end else if (st == RUN && cnt_en) begin
      if (cnt != 8'h00) begin
        cnt_n = cnt - 8'h01;
      end else begin
        term = 1'b1;
        tc_n = 1'b1;
        if (bus.MODE) cnt_n = rld;
        else          st_n  = DONE;
      end
    end
  end

`ifdef CBD38_TIMER_UFLAG_EN
  logic uf, uf_n;
  assign bus.UF = uf;

  // A terminal event wins over a same-cycle clear.
  always_comb begin
    uf_n = uf;
    if (term)           uf_n = 1'b1;
    else if (bus.UFCLR) uf_n = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (CD) uf <= 1'b0;
    else    uf <= uf_n;
  end
`endif

  always_ff @(posedge CLK) begin
    if (CD) begin
      cnt <= 8'h00;
      rld <= 8'h00;
      st  <= IDLE;
      tc  <= 1'b0;
    end else begin
      cnt <= cnt_n;
      rld <= rld_n;
      st  <= st_n;
      tc  <= tc_n;
    end
  end
endmodule

// File: tb/tb_cbd38_timer.sv
// Directed self-checking bench for cbd38_timer; UF checks compile in with CBD38_TIMER_UFLAG_EN.
module tb_cbd38_timer;
  logic CLK = 1'b0;
  logic CD  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  cbd38_timer_if tif ();
  cbd38_timer dut (.CLK(CLK), .CD(CD), .bus(tif.slave));

  always #5 CLK = ~CLK;

  function automatic logic [7:0] q();
    return {tif.Q7, tif.Q6, tif.Q5, tif.Q4, tif.Q3, tif.Q2, tif.Q1, tif.Q0};
  endfunction

  task automatic set_d(input logic [7:0] v);
    {tif.D7, tif.D6, tif.D5, tif.D4, tif.D3, tif.D2, tif.D1, tif.D0} = v;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic clr_in();
    set_d(8'h00);
    tif.BI = 0; tif.EN = 0; tif.LD = 0; tif.PS = 0; tif.START = 0; tif.MODE = 0;
`ifdef CBD38_TIMER_UFLAG_EN
    tif.UFCLR = 0;
`endif
  endtask

  task automatic do_reset();
    clr_in(); CD = 1; tick(); CD = 0;
  endtask

  // Load d with START and BI=EN=1; returns one cycle after the load edge.
  task automatic load_start(input logic [7:0] v, input logic mode);
    set_d(v); tif.LD = 1; tif.START = 1; tif.MODE = mode; tif.BI = 1; tif.EN = 1;
    tick();
    tif.LD = 0; tif.START = 0;
  endtask

  task automatic test_reset();
    clr_in(); CD = 1; tick();
    n_tests++;
    if (q() !== 8'h00 || tif.BUSY !== 1'b0 || tif.TC !== 1'b0 || tif.BO !== 1'b0) begin
      n_fail++; $display("FAIL reset: Q=%h BUSY=%b TC=%b BO=%b, want 00 0 0 0", q(), tif.BUSY, tif.TC, tif.BO);
    end
    CD = 0; tick();
    n_tests++;
    if (q() !== 8'h00 || tif.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: Q=%h BUSY=%b, want 00 0", q(), tif.BUSY);
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] exp [3] = '{8'h02, 8'h01, 8'h00};
    do_reset(); load_start(8'h03, 1'b0);
    n_tests++;
    if (q() !== 8'h03 || tif.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL oneshot_load: Q=%h BUSY=%b, want 03 1", q(), tif.BUSY);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); n_tests++;
      if (q() !== exp[i] || tif.TC !== 1'b0) begin
        n_fail++; $display("FAIL oneshot_seq[%0d]: Q=%h TC=%b, want %h 0", i, q(), tif.TC, exp[i]);
      end
    end
    n_tests++;
    if (tif.BO !== 1'b1) begin n_fail++; $display("FAIL oneshot_bo: BO=%b, want 1", tif.BO); end
    tick(); n_tests++;
    if (tif.TC !== 1'b1 || tif.BUSY !== 1'b0 || q() !== 8'h00 || tif.BO !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_tc: TC=%b BUSY=%b Q=%h BO=%b, want 1 0 00 0", tif.TC, tif.BUSY, q(), tif.BO);
    end
    tick(); tick(); n_tests++;
    if (tif.TC !== 1'b0 || q() !== 8'h00 || tif.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_done: TC=%b Q=%h BUSY=%b, want 0 00 0", tif.TC, q(), tif.BUSY);
    end
  endtask

  task automatic test_periodic();
    logic [7:0] exp [8] = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
    logic       etc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset(); load_start(8'h03, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(); n_tests++;
      if (q() !== exp[i] || tif.TC !== etc[i] || tif.BUSY !== 1'b1) begin
        n_fail++; $display("FAIL periodic[%0d]: Q=%h TC=%b BUSY=%b, want %h %b 1", i, q(), tif.TC, tif.BUSY, exp[i], etc[i]);
      end
    end
    // Reload of zero: terminal event on every enabled cycle.
    do_reset(); load_start(8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); n_tests++;
      if (q() !== 8'h00 || tif.TC !== 1'b1 || tif.BO !== 1'b1) begin
        n_fail++; $display("FAIL periodic_zero[%0d]: Q=%h TC=%b BO=%b, want 00 1 1", i, q(), tif.TC, tif.BO);
      end
    end
  endtask

  task automatic test_hold_preset_load();
    do_reset(); load_start(8'h08, 1'b1);
    tick(); tick(); tick();
    tif.EN = 0; tick(); tick(); n_tests++;
    if (q() !== 8'h05 || tif.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL en_hold: Q=%h BUSY=%b, want 05 1", q(), tif.BUSY);
    end
    tif.EN = 1; tif.BI = 0; tick(); n_tests++;
    if (q() !== 8'h05) begin n_fail++; $display("FAIL bi_hold: Q=%h, want 05", q()); end
    tif.BI = 1; tif.EN = 0;
    tif.PS = 1; tick(); tif.PS = 0; n_tests++;
    if (q() !== 8'hFF || tif.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL preset: Q=%h BUSY=%b, want ff 1", q(), tif.BUSY);
    end
    set_d(8'h10); tif.LD = 1; tick(); tif.LD = 0; n_tests++;
    if (q() !== 8'h10 || tif.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL load_run: Q=%h BUSY=%b, want 10 1", q(), tif.BUSY);
    end
    tif.EN = 1;
    for (int i = 0; i < 17; i++) tick();
    n_tests++;
    if (q() !== 8'h10 || tif.TC !== 1'b1) begin
      n_fail++; $display("FAIL rld_10: Q=%h TC=%b, want 10 1", q(), tif.TC);
    end
    // Preset on the terminal cycle suppresses the event.
    for (int i = 0; i < 16; i++) tick();
    tif.PS = 1; tick(); tif.PS = 0; n_tests++;
    if (q() !== 8'hFF || tif.TC !== 1'b0) begin
      n_fail++; $display("FAIL ps_over_term: Q=%h TC=%b, want ff 0", q(), tif.TC);
    end
  endtask

  task automatic test_reset_midcount();
    do_reset(); load_start(8'h04, 1'b0);
    tick(); tick(); n_tests++;
    if (q() !== 8'h02) begin n_fail++; $display("FAIL mid_pre: Q=%h, want 02", q()); end
    CD = 1; tick(); n_tests++;
    if (q() !== 8'h00 || tif.BUSY !== 1'b0 || tif.TC !== 1'b0 || tif.BO !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: Q=%h BUSY=%b TC=%b BO=%b, want 00 0 0 0", q(), tif.BUSY, tif.TC, tif.BO);
    end
    CD = 0; tick(); tick(); n_tests++;
    if (tif.TC !== 1'b0 || q() !== 8'h00 || tif.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL mid_after: TC=%b Q=%h BUSY=%b, want 0 00 0", tif.TC, q(), tif.BUSY);
    end
  endtask

  task automatic test_start_done();
    do_reset(); load_start(8'h07, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    n_tests++;
    if (tif.TC !== 1'b1 || tif.BUSY !== 1'b0 || q() !== 8'h00) begin
      n_fail++; $display("FAIL done_07: TC=%b BUSY=%b Q=%h, want 1 0 00", tif.TC, tif.BUSY, q());
    end
    tif.START = 1; tick(); tif.START = 0; n_tests++;
    if (q() !== 8'h07 || tif.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL restart: Q=%h BUSY=%b, want 07 1", q(), tif.BUSY);
    end
    // Load without START in IDLE stays idle and holds.
    do_reset(); set_d(8'h05); tif.LD = 1; tif.BI = 1; tif.EN = 1; tick(); tif.LD = 0;
    tick(); n_tests++;
    if (q() !== 8'h05 || tif.BUSY !== 1'b0 || tif.BO !== 1'b0) begin
      n_fail++; $display("FAIL ld_idle: Q=%h BUSY=%b BO=%b, want 05 0 0", q(), tif.BUSY, tif.BO);
    end
    tif.START = 1; tick(); tif.START = 0; n_tests++;
    if (q() !== 8'h05 || tif.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL start_idle: Q=%h BUSY=%b, want 05 1", q(), tif.BUSY);
    end
    tick(); n_tests++;
    if (q() !== 8'h04) begin n_fail++; $display("FAIL start_count: Q=%h, want 04", q()); end
  endtask

`ifdef CBD38_TIMER_UFLAG_EN
  task automatic test_uflag();
    do_reset(); n_tests++;
    if (tif.UF !== 1'b0) begin n_fail++; $display("FAIL uf_reset: UF=%b, want 0", tif.UF); end
    load_start(8'h01, 1'b0);
    tick(); tick(); n_tests++;
    if (tif.UF !== 1'b1 || tif.TC !== 1'b1) begin
      n_fail++; $display("FAIL uf_set: UF=%b TC=%b, want 1 1", tif.UF, tif.TC);
    end
    tif.UFCLR = 1; tick(); tif.UFCLR = 0; n_tests++;
    if (tif.UF !== 1'b0) begin n_fail++; $display("FAIL uf_clr: UF=%b, want 0", tif.UF); end
    tif.START = 1; tick(); tif.START = 0;
    tick(); tif.UFCLR = 1; tick(); tif.UFCLR = 0; n_tests++;
    if (tif.UF !== 1'b1 || tif.TC !== 1'b1) begin
      n_fail++; $display("FAIL uf_set_wins: UF=%b TC=%b, want 1 1", tif.UF, tif.TC);
    end
  endtask
`endif

  initial begin
    clr_in();
    test_reset();
    test_oneshot();
    test_periodic();
    test_hold_preset_load();
    test_reset_midcount();
    test_start_done();
`ifdef CBD38_TIMER_UFLAG_EN
    test_uflag();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cbd38_timer.md
CBD38_TIMER -- requirements
Module: cbd38_timer

Interface
REQ-001 SHALL have port CLK, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port CD, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have ports D0..D7, input, 1 bit each: parallel load/reload data; D0 is the LSB.
REQ-004 SHALL have port BI, input, 1 bit: borrow-in (cascade enable from the lower stage).
REQ-005 SHALL have port EN, input, 1 bit: count enable.
REQ-006 SHALL have port LD, input, 1 bit: synchronous parallel load.
REQ-007 SHALL have port PS, input, 1 bit: synchronous preset.
REQ-008 SHALL have port START, input, 1 bit: start request.
REQ-009 SHALL have port MODE, input, 1 bit: 0 = one-shot, 1 = periodic; sampled every cycle.
REQ-010 SHALL have ports Q0..Q7, output, 1 bit each: registered count; Q0 is the LSB.
REQ-011 SHALL have port BO, output, 1 bit: combinational borrow-out.
REQ-012 SHALL have port TC, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-013 SHALL have port BUSY, output, 1 bit: high while the state is RUN.

Function
REQ-014 SHALL hold an 8-bit count register CNT driving Q0..Q7, an 8-bit reload register RLD, and a state register with states IDLE, RUN, DONE.
REQ-015 SHALL apply the per-cycle priority CD > PS > LD > START > count.
REQ-016 PS SHALL set CNT=0xFF, leave RLD and the state unchanged, and force TC=0.
REQ-017 LD SHALL set CNT=D and RLD=D; in IDLE or DONE it SHALL also move the state to RUN if START is high that cycle, otherwise leave the state unchanged.
REQ-018 START without LD SHALL act as follows, by state:
- IDLE: go to RUN, CNT unchanged.
- DONE: CNT=RLD, go to RUN.
- RUN: ignored.
REQ-019 In RUN with BI&EN=1 and CNT!=0, CNT SHALL decrement by 1.
REQ-020 In RUN with BI&EN=1 and CNT==0, the block SHALL assert TC for the next cycle only, then:
- MODE=1: set CNT=RLD and stay in RUN.
- MODE=0: hold CNT=0 and go to DONE.
REQ-021 In RUN with BI&EN=0, CNT and the state SHALL hold.
REQ-022 In IDLE and DONE, CNT SHALL hold regardless of BI and EN.
REQ-023 BO SHALL equal BI & EN & (state==RUN) & (CNT==0), purely combinational, with no PS/LD gating.
REQ-024 TC SHALL be 0 in every cycle not following a terminal event (REQ-020).
REQ-025 BUSY SHALL equal (state==RUN).
REQ-026 In periodic mode with RLD=0, TC SHALL pulse on every enabled cycle.

Reset
REQ-027 CD=1 at a rising CLK edge SHALL set CNT=0x00, RLD=0x00, state=IDLE, TC=0, and UF=0 when present, overriding all other inputs that cycle.
REQ-028 While CD=1, BO and BUSY SHALL read 0 from the following cycle onward.
REQ-029 CD asserted mid-count SHALL abandon the run with no TC pulse.

Configuration
REQ-030 SHALL compile in sticky underflow logic when macro CBD38_TIMER_UFLAG_EN is defined, adding port UFCLR (input, 1 bit) and port UF (output, 1 bit, registered).
REQ-031 With the macro defined, UF SHALL set on every terminal event and clear on UFCLR=1; set SHALL win if both occur in the same cycle.
REQ-032 Without the macro, ports UF and UFCLR SHALL NOT exist and the remaining behaviour SHALL be identical.

Verification
REQ-033 CD=1 for one cycle, then all other inputs 0 -> Q=0x00, BUSY=0, TC=0, BO=0.
REQ-034 LD with D=0x03 plus START, MODE=0, BI=EN=1:
- Q sequence 03,02,01,00.
- BO=1 in the cycle Q=00.
- TC=1 for exactly one cycle afterwards.
- State DONE, BUSY=0, Q holds 00.
REQ-035 Same load with MODE=1 -> Q sequence 03,02,01,00,03,02…, with a TC pulse after each 00.
REQ-036 During RUN at Q=0x05: toggle EN low for 2 cycles -> Q holds 05; assert PS -> Q=0xFF, BUSY stays 1; assert LD with D=0x10 -> Q=0x10, RLD=0x10.
REQ-037 Reset mid-count and simultaneous events:
- CD during RUN at Q=0x02 -> Q=00, IDLE, no TC.
- START in DONE after a reload of 0x07 -> Q=07, BUSY=1.
REQ-038 With CBD38_TIMER_UFLAG_EN defined, expire a one-shot run -> UF=1; pulse UFCLR -> UF=0; UFCLR coinciding with a terminal event -> UF=1.
